// File: rtl/pc_gen.sv
// Fetch-PC generator: holds the virtual fetch PC, applies flush and branch redirects,
// buffers a branch that arrives during a fetch stall, and raises fetch exceptions.
module pc_gen #(
   parameter int          ADDR_W       = 32,
   parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
   parameter int          FETCH_BYTES  = 4,
   parameter int          STALL_W      = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic [ADDR_W-1:0]  new_pc,
   input  logic               branch_flag_i,
   input  logic [ADDR_W-1:0]  branch_target_addr_i,
   input  logic               tlb_hit,
   input  logic [ADDR_W-1:0]  physical_pc,
   output logic [ADDR_W-1:0]  virtual_pc,
   output logic [ADDR_W-1:0]  pc,
   output logic               ce,
   output logic [31:0]        excepttype_o,
   output logic               redirect_pending_o
);

   localparam logic [ADDR_W-1:0] L_RESET_PC = ADDR_W'(RESET_VECTOR);
   localparam logic [ADDR_W-1:0] L_STRIDE   = ADDR_W'(FETCH_BYTES);
   localparam logic [31:0]       L_EXC_ADEL = 32'h0000_4000;
   localparam logic [31:0]       L_EXC_TLBL = 32'h0000_2000;

   typedef enum logic [1:0] {
      S_RESET   = 2'd0,
      S_RUN     = 2'd1,
      S_HOLD_BR = 2'd2
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_virtualPc;
   logic [ADDR_W-1:0] r_target;
   logic              r_ce;
   logic              r_pending;

   state_t            w_nextState;
   logic [ADDR_W-1:0] w_nextVirtualPc;
   logic [ADDR_W-1:0] w_nextTarget;
   logic              w_nextCe;
   logic              w_nextPending;
   logic [ADDR_W-1:0] w_seqPc;
   logic              w_fetchStall;

   // Only the fetch-stage stall bit matters here; the rest belong to later stages.
   logic              w_unusedStall;
   assign w_unusedStall = ^stall;

   assign w_fetchStall = stall[0];
   assign w_seqPc      = r_virtualPc + L_STRIDE;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_RESET;
         r_virtualPc <= L_RESET_PC;
         r_target    <= '0;
         r_ce        <= 1'b0;
         r_pending   <= 1'b0;
      end else begin
         r_state     <= w_nextState;
         r_virtualPc <= w_nextVirtualPc;
         r_target    <= w_nextTarget;
         r_ce        <= w_nextCe;
         r_pending   <= w_nextPending;
      end
   end

   always_comb begin
      w_nextState     = r_state;
      w_nextVirtualPc = r_virtualPc;
      w_nextTarget    = r_target;
      w_nextCe        = r_ce;
      w_nextPending   = r_pending;
      case (r_state)
         S_RESET: begin
            w_nextState = S_RUN;
            w_nextCe    = 1'b1;
         end
         S_RUN: begin
            if (flush) begin
               w_nextVirtualPc = new_pc;
            end else if (!w_fetchStall) begin
               w_nextVirtualPc = branch_flag_i ? branch_target_addr_i : w_seqPc;
            end else if (branch_flag_i) begin
               w_nextTarget  = branch_target_addr_i;
               w_nextState   = S_HOLD_BR;
               w_nextPending = 1'b1;
            end
         end
         S_HOLD_BR: begin
            // A flush outranks the buffered branch, which is then discarded.
            if (flush) begin
               w_nextVirtualPc = new_pc;
               w_nextTarget    = '0;
               w_nextState     = S_RUN;
               w_nextPending   = 1'b0;
            end else if (!w_fetchStall) begin
               w_nextVirtualPc = r_target;
               w_nextState     = S_RUN;
               w_nextPending   = 1'b0;
            end else if (branch_flag_i) begin
               w_nextTarget = branch_target_addr_i;
            end
         end
         default: begin
            w_nextState     = S_RESET;
            w_nextVirtualPc = L_RESET_PC;
            w_nextTarget    = '0;
            w_nextCe        = 1'b0;
            w_nextPending   = 1'b0;
         end
      endcase
   end

   always_comb begin
      pc           = '0;
      excepttype_o = '0;
      if (r_ce) begin
         if (r_virtualPc[1:0] != 2'b00) begin
            excepttype_o = L_EXC_ADEL;
         end else if (!tlb_hit) begin
            excepttype_o = L_EXC_TLBL;
         end else begin
            pc = physical_pc;
         end
      end
   end

   assign virtual_pc         = r_virtualPc;
   assign ce                 = r_ce;
   assign redirect_pending_o = r_pending;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: a directed vector table, a wrap sequence on a stride-8 instance,
// and randomized traffic compared against a rule-level reference model.
module tb_pc_gen;

   localparam logic [31:0] P = 32'h1FC00000;

   logic        clk;
   logic        rst;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] newPc;
   logic        brFlag;
   logic [31:0] brTarget;
   logic        tlbHit;
   logic [31:0] physPc;

   logic [31:0] vpc0, pc0, exc0, vpc1, pc1, exc1;
   logic        ce0, pend0, ce1, pend1;

   int testsRun = 0;
   int failures = 0;

   pc_gen dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(newPc),
      .branch_flag_i(brFlag), .branch_target_addr_i(brTarget), .tlb_hit(tlbHit),
      .physical_pc(physPc), .virtual_pc(vpc0), .pc(pc0), .ce(ce0),
      .excepttype_o(exc0), .redirect_pending_o(pend0)
   );

   pc_gen #(.FETCH_BYTES(8)) dut8 (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(newPc),
      .branch_flag_i(brFlag), .branch_target_addr_i(brTarget), .tlb_hit(tlbHit),
      .physical_pc(physPc), .virtual_pc(vpc1), .pc(pc1), .ce(ce1),
      .excepttype_o(exc1), .redirect_pending_o(pend1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: one entry per instance (0 = stride 4, 1 = stride 8).
   logic [31:0] mVpc[2];
   logic [31:0] mTgt[2];
   logic        mCe[2];
   logic        mPend[2];
   logic        mInReset[2];
   int          mStride[2] = '{4, 8};

   task automatic modelEdge();
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            mInReset[k] = 1'b1; mCe[k] = 1'b0; mVpc[k] = 32'hBFC00000;
            mPend[k] = 1'b0; mTgt[k] = 32'h0;
         end else if (mInReset[k]) begin
            mInReset[k] = 1'b0; mCe[k] = 1'b1;
         end else if (mPend[k]) begin
            if (flush) begin mVpc[k] = newPc; mPend[k] = 1'b0; end
            else if (!stall[0]) begin mVpc[k] = mTgt[k]; mPend[k] = 1'b0; end
            else if (brFlag) mTgt[k] = brTarget;
         end else begin
            if (flush) mVpc[k] = newPc;
            else if (!stall[0]) mVpc[k] = brFlag ? brTarget : 32'((64'(mVpc[k]) + 64'(mStride[k])) % 64'h1_0000_0000);
            else if (brFlag) begin mTgt[k] = brTarget; mPend[k] = 1'b1; end
         end
      end
   endtask

   function automatic logic [31:0] expPc(int k);
      if (mCe[k] && (mVpc[k] % 4 == 0) && tlbHit) return physPc;
      return 32'h0;
   endfunction

   function automatic logic [31:0] expExc(int k);
      if (!mCe[k]) return 32'h0;
      if (mVpc[k] % 4 != 0) return 32'h1 << 14;
      if (!tlbHit) return 32'h1 << 13;
      return 32'h0;
   endfunction

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic checkOutput();
      checkVal("vpc0", vpc0, mVpc[0]);
      checkVal("ce0", 32'(ce0), 32'(mCe[0]));
      checkVal("pend0", 32'(pend0), 32'(mPend[0]));
      checkVal("pc0", pc0, expPc(0));
      checkVal("exc0", exc0, expExc(0));
      checkVal("vpc1", vpc1, mVpc[1]);
      checkVal("ce1", 32'(ce1), 32'(mCe[1]));
      checkVal("pend1", 32'(pend1), 32'(mPend[1]));
      checkVal("pc1", pc1, expPc(1));
      checkVal("exc1", exc1, expExc(1));
   endtask

   task automatic applyStimulus(input logic r, input logic [5:0] s, input logic f,
                                input logic [31:0] np, input logic b, input logic [31:0] t,
                                input logic h, input logic [31:0] p);
      rst = r; stall = s; flush = f; newPc = np;
      brFlag = b; brTarget = t; tlbHit = h; physPc = p;
   endtask

   task automatic step();
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput();
   endtask

   typedef struct {
      logic        rst;
      logic        stall0;
      logic        flush;
      logic [31:0] newPc;
      logic        br;
      logic [31:0] target;
      logic        tlb;
      logic [31:0] phys;
      logic [31:0] eVpc;
      logic        eCe;
      logic        ePend;
      logic [31:0] ePc;
      logic [31:0] eExc;
   } vec_t;

   vec_t vecs[20];

   initial begin
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, P, 32'hBFC00000, 1'b0, 1'b0, 32'h0, 32'h0};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, P, 32'hBFC00000, 1'b0, 1'b0, 32'h0, 32'h0};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, P, 32'hBFC00000, 1'b1, 1'b0, P, 32'h0};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, P, 32'hBFC00004, 1'b1, 1'b0, P, 32'h0};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, P, 32'hBFC00008, 1'b1, 1'b0, P, 32'h0};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h80001000, 1'b1, P, 32'hBFC00008, 1'b1, 1'b1, P, 32'h0};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, P, 32'hBFC00008, 1'b1, 1'b1, P, 32'h0};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, P, 32'hBFC00008, 1'b1, 1'b1, P, 32'h0};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, P, 32'hBFC00008, 1'b1, 1'b1, P, 32'h0};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, P, 32'h80001000, 1'b1, 1'b0, P, 32'h0};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h80002000, 1'b1, P, 32'h80001000, 1'b1, 1'b1, P, 32'h0};
      vecs[11] = '{1'b0, 1'b1, 1'b1, 32'hBFC00380, 1'b0, 32'h0, 1'b1, P, 32'hBFC00380, 1'b1, 1'b0, P, 32'h0};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, P, 32'hBFC00384, 1'b1, 1'b0, P, 32'h0};
      vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80000002, 1'b1, P, 32'h80000002, 1'b1, 1'b0, 32'h0, 32'h00004000};
      vecs[14] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, P, 32'h80000002, 1'b1, 1'b0, 32'h0, 32'h00004000};
      vecs[15] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80000004, 1'b0, P, 32'h80000004, 1'b1, 1'b0, 32'h0, 32'h00002000};
      vecs[16] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h4, 32'h80000004, 1'b1, 1'b0, 32'h4, 32'h0};
      vecs[17] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h80003000, 1'b1, 32'h4, 32'h80000004, 1'b1, 1'b1, 32'h4, 32'h0};
      vecs[18] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h4, 32'hBFC00000, 1'b0, 1'b0, 32'h0, 32'h0};
      vecs[19] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, P, 32'hBFC00000, 1'b1, 1'b0, P, 32'h0};

      applyStimulus(1'b1, 6'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, P);

      for (int i = 0; i < 20; i++) begin
         applyStimulus(vecs[i].rst, {5'b0, vecs[i].stall0}, vecs[i].flush, vecs[i].newPc,
                       vecs[i].br, vecs[i].target, vecs[i].tlb, vecs[i].phys);
         step();
         checkVal($sformatf("vec%0d.vpc", i), vpc0, vecs[i].eVpc);
         checkVal($sformatf("vec%0d.ce", i), 32'(ce0), 32'(vecs[i].eCe));
         checkVal($sformatf("vec%0d.pend", i), 32'(pend0), 32'(vecs[i].ePend));
         checkVal($sformatf("vec%0d.pc", i), pc0, vecs[i].ePc);
         checkVal($sformatf("vec%0d.exc", i), exc0, vecs[i].eExc);
      end

      // Address wrap: both instances jump to the top of the space, then advance.
      applyStimulus(1'b0, 6'h01, 1'b1, 32'hFFFFFFF8, 1'b0, 32'h0, 1'b1, P);
      step();
      applyStimulus(1'b0, 6'h00, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, P);
      step();
      checkVal("wrap.stride8", vpc1, 32'h00000000);
      checkVal("wrap.stride4", vpc0, 32'hFFFFFFFC);
      step();
      checkVal("wrap.stride4.next", vpc0, 32'h00000000);
      checkVal("wrap.stride8.next", vpc1, 32'h00000008);

      // Randomized traffic against the reference model.
      for (int n = 0; n < 400; n++) begin
         logic [31:0] t;
         t = $urandom;
         if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
         applyStimulus(($urandom_range(0, 49) == 0), 6'($urandom),
                       ($urandom_range(0, 9) == 0), {$urandom, 2'b00} >> 0,
                       ($urandom_range(0, 3) == 0), t,
                       ($urandom_range(0, 4) != 0), $urandom);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, failures);
      $finish;
   end

endmodule
